// File: rtl/cntry_vehicle_detector.sv
// Country-road loop conditioner: sync, debounce, vehicle queue count,
// GREEN-driven drain and stuck-loop fail-safe request.
module cntry_vehicle_detector #(
  parameter int DEB_CYC   = 4,
  parameter int DRAIN_CYC = 8,
  parameter int STUCK_CYC = 1024,
  parameter int CW        = 4
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          loop_raw,
  input  logic [1:0]    cntry,
  output logic          traffic,
  output logic [CW-1:0] veh_count,
  output logic          sat,
  output logic          stuck
);

  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int TW = $clog2(DRAIN_CYC + 1);
  localparam int SW = $clog2(STUCK_CYC + 1);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(DRAIN_CYC - 1);
  localparam logic [SW-1:0] STK_MAX  = SW'(STUCK_CYC);

  typedef enum logic [1:0] {
    ABSENT,
    ARRIVING,
    PRESENT,
    LEAVING
  } st_e;

  logic          sync1_q, s_q;
  st_e           state_q, state_d;
  logic [DW-1:0] deb_q, deb_d, deb_inc;
  logic          deb_hit;
  logic          p, arrive, leave;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [CW-1:0] veh_q, veh_d;
  logic          sat_q, sat_d;
  logic [SW-1:0] stk_q, stk_d;
  logic          stuck_q, stuck_d;
  logic          busy, tick, full;

  // Two-flop synchronizer for the asynchronous loop input
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
    end else begin
      sync1_q <= loop_raw;
      s_q     <= sync1_q;
    end
  end

  // Debounce state and run-length counter registers
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= ABSENT;
      deb_q   <= '0;
    end else begin
      state_q <= state_d;
      deb_q   <= deb_d;
    end
  end

  // The current sample completes the run when deb_q already holds DEB_CYC-1
  assign deb_hit = (deb_q == DEB_LAST);
  assign deb_inc = deb_hit ? '0 : deb_q + DW'(1);

  // Debounce next state: a level change needs DEB_CYC agreeing samples
  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    unique case (state_q)
      ABSENT: begin
        if (s_q) begin
          state_d = deb_hit ? PRESENT : ARRIVING;
          deb_d   = deb_inc;
        end
      end
      ARRIVING: begin
        if (!s_q) begin
          state_d = ABSENT;
          deb_d   = '0;
        end else begin
          if (deb_hit) state_d = PRESENT;
          deb_d = deb_inc;
        end
      end
      PRESENT: begin
        if (!s_q) begin
          state_d = deb_hit ? ABSENT : LEAVING;
          deb_d   = deb_inc;
        end
      end
      LEAVING: begin
        if (s_q) begin
          state_d = PRESENT;
          deb_d   = '0;
        end else begin
          if (deb_hit) state_d = ABSENT;
          deb_d = deb_inc;
        end
      end
      default: begin
        state_d = ABSENT;
        deb_d   = '0;
      end
    endcase
  end

  // Debounce outputs: filtered presence and its edge pulses
  always_comb begin
    p      = (state_q == PRESENT) || (state_q == LEAVING);
    arrive = !p && (state_d == PRESENT);
    leave  = p && (state_d == ABSENT);
  end

  assign busy = (cntry == 2'd2) && (veh_q != '0);
  assign tick = busy && (tmr_q == TMR_LAST);
  assign full = (veh_q == '1);

  // Queue, drain timer and stuck detector next-state
  always_comb begin
    tmr_d = '0;
    veh_d = veh_q;
    sat_d = sat_q;
    stk_d = stk_q;
    if (busy && !tick) tmr_d = tmr_q + TW'(1);
    if (arrive && !tick) begin
      if (full) sat_d = 1'b1;
      else      veh_d = veh_q + CW'(1);
    end else if (tick && !arrive) begin
      veh_d = veh_q - CW'(1);
    end
    if (leave)                     stk_d = '0;
    else if (p && stk_q != STK_MAX) stk_d = stk_q + SW'(1);
    stuck_d = (stk_d == STK_MAX);
  end

  // Queue, drain timer and stuck detector registers
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      tmr_q   <= '0;
      veh_q   <= '0;
      sat_q   <= 1'b0;
      stk_q   <= '0;
      stuck_q <= 1'b0;
    end else begin
      tmr_q   <= tmr_d;
      veh_q   <= veh_d;
      sat_q   <= sat_d;
      stk_q   <= stk_d;
      stuck_q <= stuck_d;
    end
  end

  assign traffic   = (veh_q != '0) || stuck_q;
  assign veh_count = veh_q;
  assign sat       = sat_q;
  assign stuck     = stuck_q;

endmodule

// File: tb/tb_cntry_vehicle_detector.sv
// Directed and randomized bench for cntry_vehicle_detector with a
// cycle-level reference model built from the behavioural rules.
module tb_cntry_vehicle_detector;

  localparam int DEB   = 4;
  localparam int DRAIN = 8;
  localparam int STUCK = 1024;
  localparam int CW    = 4;
  localparam int MAXV  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          clear;
  logic          loop_raw;
  logic [1:0]    cntry;
  logic          traffic;
  logic [CW-1:0] veh_count;
  logic          sat;
  logic          stuck;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit m_sync1, m_s, m_p, m_sat, m_stuck;
  int m_veh, m_g, m_pc;
  bit m_hist[$];

  always #5 clk = ~clk;

  cntry_vehicle_detector #(
    .DEB_CYC  (DEB),
    .DRAIN_CYC(DRAIN),
    .STUCK_CYC(STUCK),
    .CW       (CW)
  ) dut (
    .clk      (clk),
    .clear    (clear),
    .loop_raw (loop_raw),
    .cntry    (cntry),
    .traffic  (traffic),
    .veh_count(veh_count),
    .sat      (sat),
    .stuck    (stuck)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    m_sync1 = 0; m_s = 0; m_p = 0; m_sat = 0; m_stuck = 0;
    m_veh = 0; m_g = 0; m_pc = 0;
    m_hist.delete();
  endtask

  // one clock edge of the behavioural model, using pre-edge inputs
  task automatic model_edge();
    bit p_old, arr, lv, green, tk;
    p_old = m_p;
    arr = 0;
    lv = 0;
    // p flips once DEB samples in a row disagree with it
    if (m_s == m_p) m_hist.delete();
    else begin
      m_hist.push_back(m_s);
      if (m_hist.size() == DEB) begin
        m_p = !m_p;
        arr = m_p;
        lv = !m_p;
        m_hist.delete();
      end
    end
    green = (cntry == 2'd2) && (m_veh != 0);
    tk = green && (m_g + 1 == DRAIN);
    m_g = (green && !tk) ? m_g + 1 : 0;
    if (arr && !tk) begin
      if (m_veh == MAXV) m_sat = 1;
      else m_veh = m_veh + 1;
    end else if (tk && !arr) m_veh = m_veh - 1;
    if (lv) m_pc = 0;
    else if (p_old && m_pc < STUCK) m_pc = m_pc + 1;
    m_stuck = (m_pc == STUCK);
    m_s = m_sync1;
    m_sync1 = loop_raw;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (clear) mreset();
    else model_edge();
    #1;
    chk("m_veh", veh_count, m_veh);
    chk("m_traffic", traffic, (m_veh != 0) || m_stuck);
    chk("m_sat", sat, m_sat);
    chk("m_stuck", stuck, m_stuck);
  endtask

  task automatic do_reset();
    clear = 1;
    loop_raw = 0;
    cntry = 0;
    mreset();
    cyc();
    cyc();
    clear = 0;
    cyc();
  endtask

  task automatic arrive1();
    loop_raw = 1;
    repeat (8) cyc();
    loop_raw = 0;
    repeat (8) cyc();
  endtask

  initial begin
    clear = 1;
    loop_raw = 1;
    cntry = 2;
    mreset();
    #1;
    chk("rst_veh", veh_count, 0);
    chk("rst_traffic", traffic, 0);
    chk("rst_sat", sat, 0);
    chk("rst_stuck", stuck, 0);
    repeat (3) cyc();
    chk("rst_hold_veh", veh_count, 0);
    chk("rst_hold_traffic", traffic, 0);
    clear = 0;
    repeat (5) cyc();
    chk("rel_edge4_veh", veh_count, 0);
    cyc();
    chk("rel_edge5_veh", veh_count, 1);
    chk("rel_edge5_traffic", traffic, 1);

    // bounce rejection
    do_reset();
    for (int w = 1; w <= 3; w++) begin
      loop_raw = 1;
      repeat (w) cyc();
      loop_raw = 0;
      repeat (3) cyc();
    end
    repeat (4) cyc();
    chk("bounce_veh", veh_count, 0);
    chk("bounce_traffic", traffic, 0);
    loop_raw = 1;
    repeat (10) cyc();
    loop_raw = 0;
    repeat (8) cyc();
    chk("clean_veh", veh_count, 1);

    // drain three vehicles
    do_reset();
    repeat (3) arrive1();
    chk("queue3", veh_count, 3);
    cntry = 2;
    repeat (7) cyc();
    chk("drain_g7", veh_count, 3);
    cyc();
    chk("drain_g8", veh_count, 2);
    repeat (7) cyc();
    chk("drain_g15", veh_count, 2);
    cyc();
    chk("drain_g16", veh_count, 1);
    repeat (7) cyc();
    chk("drain_g23_traffic", traffic, 1);
    cyc();
    chk("drain_g24", veh_count, 0);
    chk("drain_g24_traffic", traffic, 0);

    // yellow interruption restarts the timer
    do_reset();
    repeat (3) arrive1();
    cntry = 2;
    repeat (12) cyc();
    chk("yel_g12", veh_count, 2);
    cntry = 1;
    repeat (3) cyc();
    chk("yel_hold", veh_count, 2);
    cntry = 2;
    repeat (7) cyc();
    chk("yel_restart7", veh_count, 2);
    cyc();
    chk("yel_restart8", veh_count, 1);

    // saturation and arrival coinciding with a drain tick
    do_reset();
    repeat (15) arrive1();
    chk("sat15_veh", veh_count, 15);
    chk("sat15_flag", sat, 0);
    arrive1();
    chk("sat16_veh", veh_count, 15);
    chk("sat16_flag", sat, 1);
    cntry = 2;
    repeat (2) cyc();
    loop_raw = 1;
    repeat (5) cyc();
    chk("coin_pre", veh_count, 15);
    cyc();
    chk("coin_edge", veh_count, 15);
    repeat (7) cyc();
    chk("coin_g15", veh_count, 15);
    cyc();
    chk("coin_g16", veh_count, 14);
    loop_raw = 0;
    cntry = 0;
    repeat (8) cyc();

    // stuck loop fail-safe
    do_reset();
    cntry = 2;
    loop_raw = 1;
    repeat (1029) cyc();
    chk("stuck_pre", stuck, 0);
    chk("stuck_pre_veh", veh_count, 0);
    cyc();
    chk("stuck_set", stuck, 1);
    chk("stuck_traffic", traffic, 1);
    repeat (70) cyc();
    loop_raw = 0;
    cyc();
    chk("stuck_hold", stuck, 1);
    repeat (DEB + 2) cyc();
    chk("stuck_clr", stuck, 0);
    chk("stuck_clr_traffic", traffic, 0);

    // asynchronous clear mid-drain
    do_reset();
    repeat (5) arrive1();
    cntry = 2;
    repeat (3) cyc();
    chk("async_pre", veh_count, 5);
    #2;
    clear = 1;
    mreset();
    #1;
    chk("async_veh", veh_count, 0);
    chk("async_traffic", traffic, 0);
    cyc();
    clear = 0;
    cyc();

    // randomized runs against the model
    for (int k = 0; k < 250; k++) begin
      loop_raw = 1'($urandom_range(0, 1));
      cntry = 2'($urandom_range(0, 3));
      repeat ($urandom_range(1, 14)) cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cntry_vehicle_detector.md
# cntry_vehicle_detector

Conditions the raw country-road inductive-loop signal and produces the `traffic` request consumed by the highway/country traffic light controller. It synchronizes and debounces the loop input and counts queued vehicles. The queue drains while the country light shows GREEN, and a stuck loop is forced into a fail-safe request. It sits directly upstream of the light controller: its `traffic` output drives the controller's `traffic` input, and the controller's `cntry` output feeds back into this block.

## Interface
- `DEB_CYC`, 4: consecutive synchronized samples needed to accept a loop level change (≥1).
- `DRAIN_CYC`, 8: GREEN cycles per discharged vehicle (≥1).
- `STUCK_CYC`, 1024: continuous presence cycles before the loop is declared stuck (≥2).
- `CW`, 4: queue counter width; the queue saturates at 2^CW−1.

- `clk`  in  1  system clock, rising edge.
- `clear`  in  1  asynchronous, active-high reset.
- `loop_raw`  in  1  raw loop detector output, asynchronous to `clk`, may bounce.
- `cntry`  in  2  country light state from the controller: 0=RED, 1=YELLOW, 2=GREEN.
- `traffic`  out  1  request to the controller: (`veh_count`≠0) OR `stuck`.
- `veh_count`  out  CW  vehicles waiting.
- `sat`  out  1  sticky flag: an arrival was dropped because the queue was full.
- `stuck`  out  1  loop held present for ≥STUCK_CYC cycles.

## Operation
- Synchronizer: two flops on `loop_raw` produce `s`. Both flops reset to 0.
- Debounce FSM, filtered presence `p`:
  - ABSENT (p=0): `s`=1 → ARRIVING.
  - ARRIVING: `s`=0 → ABSENT. DEB_CYC consecutive `s`=1 samples (counted from the entry sample) → PRESENT, p=1.
  - PRESENT (p=1): `s`=0 → LEAVING.
  - LEAVING: `s`=1 → PRESENT. DEB_CYC consecutive `s`=0 samples → ABSENT, p=0.
  - The debounce counter clears on every abort and on every completed transition.
- Arrival: on the ARRIVING→PRESENT edge, `veh_count` increments. If `veh_count` is already 2^CW−1, it holds and `sat` is set. `sat` clears only on `clear`.
- Drain: the drain timer counts while `cntry`==2 and `veh_count`≠0.
  - When the timer reaches DRAIN_CYC, `veh_count` decrements and the timer restarts.
  - The timer zeroes whenever `cntry`≠2 or `veh_count`==0.
  - `cntry` value 3 is treated as not GREEN.
- Simultaneous arrival and drain tick in one cycle: `veh_count` is unchanged. At saturation, the drain wins and `sat` is not set.
- Stuck detector: counts cycles with p=1 and saturates at STUCK_CYC.
  - `stuck` is set when the count reaches STUCK_CYC.
  - `stuck` and the count clear when p returns to 0 (LEAVING→ABSENT).
  - While `stuck`=1, `traffic`=1 regardless of `veh_count`.
- `traffic` is a combinational OR of registered `veh_count`≠0 and registered `stuck`.

## Timing
- Reset values, applied asynchronously on `clear`=1: synchronizer 0, FSM ABSENT, all timers 0, `veh_count`=0, `sat`=0, `stuck`=0, `traffic`=0.
- Release of `clear` takes effect at the first rising edge after deassertion. Reset mid-queue discards all counts immediately.
- Arrival latency: with `loop_raw` rising before edge 0, `s`=1 after edge 1, and `veh_count`/`traffic` update at edge 1+DEB_CYC (edge 5 with defaults).
- Glitch rejection: `loop_raw` pulses shorter than DEB_CYC cycles never change p.
- Drain latency: the first decrement occurs at the DRAIN_CYC-th edge with `cntry`==2. `traffic` falls in the same cycle `veh_count` reaches 0.
- `stuck` asserts at the STUCK_CYC-th edge after p rises.

## Test plan
- Reset: hold `clear` with `loop_raw`=1 and `cntry`=2 → all outputs 0. Release and hold `loop_raw`=1 → `veh_count`=1 and `traffic`=1 at edge 5 after release.
- Bounce: `loop_raw` pulses of 1, 2, and 3 cycles, separated by 3-cycle gaps → `veh_count` stays 0 and `traffic` stays 0. A 10-cycle clean pulse → `veh_count`=1.
- Drain: queue 3 vehicles with `cntry`=0, then `cntry`=2 → `veh_count` becomes 2, 1, 0 at GREEN cycles 8, 16, 24, and `traffic` falls at cycle 24. Drop `cntry` to 1 at GREEN cycle 12 → count holds at 2 and the timer restarts.
- Saturation: 16 clean arrivals with `cntry`=0 → `veh_count`=15, `sat`=1. Then an arrival on the same edge as a drain tick → `veh_count`=15 is unchanged at that edge.
- Stuck loop: `loop_raw`=1 for 1100 cycles with `cntry`=2 → queue drains to 0 and `stuck`=1 at p-cycle 1024, keeping `traffic`=1. Release the loop → `stuck` clears 3+DEB_CYC edges later and `traffic`=0.
- Async reset mid-drain: assert `clear` between clock edges with `veh_count`=5 → `veh_count`=0 and `traffic`=0 before the next edge.
